// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register bank.
// Used by spi_reg_bank and spi_poci_shifter.
package spi_pkg;

  localparam logic [7:0] CHIP_ID   = 8'h6C;
  localparam int         TXN_EDGES = 17;
  localparam int         CMD_BITS  = 8;
  localparam logic [6:0] ADDR_ID   = 7'h7F;

  typedef logic [6:0] addr_t;
  typedef logic [7:0] byte_t;
  typedef logic [4:0] cnt_t;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_DATA,
    ST_COMMIT,
    ST_DONE
  } state_e;

  function automatic state_e state_of(input cnt_t c);
    if (c < cnt_t'(CMD_BITS))
      return ST_CMD;
    else if (c < cnt_t'(2 * CMD_BITS))
      return ST_DATA;
    else if (c == cnt_t'(2 * CMD_BITS))
      return ST_COMMIT;
    else
      return ST_DONE;
  endfunction

endpackage

// File: rtl/spi_poci_shifter.sv
// Readback shift register: parallel load, shift left, MSB out.
// Cleared asynchronously whenever the transaction is aborted.
import spi_pkg::*;

module spi_poci_shifter (
  input  logic  clk,
  input  logic  clr_n,
  input  logic  load,
  input  logic  shift,
  input  byte_t din,
  output logic  poci
);

  byte_t sr_q;

  // load the read value, then walk it out MSB first
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      sr_q <= '0;
    else if (load)
      sr_q <= din;
    else if (shift)
      sr_q <= {sr_q[6:0], 1'b0};
  end

  assign poci = sr_q[7];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI register bank: 17-edge transactions, 8-bit registers.
// Readback path present only with SPI_REG_READBACK_EN defined.
import spi_pkg::*;

module spi_reg_bank #(
  parameter int NUM_REGS = 16
) (
  input  logic                  spi_clk,
  input  logic                  rstn,
  input  logic                  cs,
  input  logic                  is_write,
  input  logic [6:0]            addr,
  input  logic [7:0]            wdata,
  output logic                  poci,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  write_strobe
);

  cnt_t   cnt_q;
  cnt_t   cnt_d;
  state_e state_q;
  state_e state_d;
  logic   latch;
  logic   commit;
  logic   wr_q;
  addr_t  addr_q;
  logic   armed_q;
  logic   arm_set;
  logic   clr_n;
  logic [NUM_REGS*8-1:0] regs_q;

  // a reset taken with cs low leaves the bank idle until cs goes high
  assign arm_set = cs & rstn;

  // arm on cs high (or reset release while cs high)
  always_ff @(posedge arm_set or negedge rstn) begin
    if (!rstn)
      armed_q <= 1'b0;
    else
      armed_q <= 1'b1;
  end

  assign clr_n = rstn & ~cs & armed_q;

  assign cnt_d = (cnt_q == cnt_t'(TXN_EDGES)) ?
                 cnt_q : cnt_q + cnt_t'(1);

  // edge counter, saturating at the final edge
  always_ff @(posedge spi_clk or negedge clr_n) begin
    if (!clr_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // fsm state register
  always_ff @(posedge spi_clk or negedge clr_n) begin
    if (!clr_n)
      state_q <= ST_CMD;
    else
      state_q <= state_d;
  end

  // next state follows the next count
  always_comb begin
    state_d = state_of(cnt_d);
  end

  // fsm outputs: command latch and commit enables
  always_comb begin
    latch  = 1'b0;
    commit = 1'b0;
    unique case (1'b1)
      (state_q == ST_CMD),
      (state_q == ST_DONE): ;
      (state_q == ST_DATA):
        latch = (cnt_q == cnt_t'(CMD_BITS));
      (state_q == ST_COMMIT):
        commit = 1'b1;
    endcase
  end

  // capture the command on the first data edge
  always_ff @(posedge spi_clk or negedge rstn) begin
    if (!rstn) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else if (latch) begin
      wr_q   <= is_write;
      addr_q <= addr;
    end
  end

  // one-edge pulse after a write commit
  always_ff @(posedge spi_clk or negedge clr_n) begin
    if (!clr_n)
      write_strobe <= 1'b0;
    else
      write_strobe <= commit & wr_q;
  end

  // register file; out-of-range and id writes land nowhere
  always_ff @(posedge spi_clk or negedge rstn) begin
    if (!rstn) begin
      regs_q <= '0;
    end else if (commit && wr_q) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (addr_q == addr_t'(i))
          regs_q[i*8 +: 8] <= wdata;
    end
  end

  assign regs_out = regs_q;

`ifdef SPI_REG_READBACK_EN
  byte_t rd_val;
  logic  shift;
  logic  rd_active;
  logic  sh_bit;

  // read mux: register, chip id, or zero
  always_comb begin
    rd_val = (addr == ADDR_ID) ? CHIP_ID : 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (addr == addr_t'(i))
        rd_val = regs_q[i*8 +: 8];
  end

  assign shift = (state_q == ST_DATA) && !latch;

  assign rd_active = !wr_q &&
                     ((state_q == ST_DATA && !latch) ||
                      state_q == ST_COMMIT);

  spi_poci_shifter u_shift (
    .clk   (spi_clk),
    .clr_n (clr_n),
    .load  (latch & ~is_write),
    .shift (shift),
    .din   (rd_val),
    .poci  (sh_bit)
  );

  assign poci = sh_bit & rd_active;
`else
  assign poci = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank.
// Directed transactions; monitor compares per transaction.
module tb_spi_reg_bank;

  localparam int NR = 16;

  logic          spi_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cs = 1'b1;
  logic          is_write = 1'b0;
  logic [6:0]    addr = '0;
  logic [7:0]    wdata = '0;
  logic          poci;
  logic          write_strobe;
  logic [NR*8-1:0] regs_out;

  spi_reg_bank #(.NUM_REGS(NR)) dut (
    .spi_clk      (spi_clk),
    .rstn         (rstn),
    .cs           (cs),
    .is_write     (is_write),
    .addr         (addr),
    .wdata        (wdata),
    .poci         (poci),
    .regs_out     (regs_out),
    .write_strobe (write_strobe)
  );

  always #5 spi_clk = ~spi_clk;

  typedef struct {
    string           name;
    logic [31:0]     pb;
    logic [31:0]     sb;
    logic [NR*8-1:0] regs;
  } exp_t;

  exp_t            q[$];
  logic [NR*8-1:0] mdl = '0;
  int              n_cmp = 0;
  int              n_bad = 0;

  function automatic logic [7:0] rdexp(input logic [7:0] v);
`ifdef SPI_REG_READBACK_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction

  // poci bit sampled after edge 9 is the MSB, after edge 16 the LSB
  function automatic logic [31:0] pmask(input logic [7:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r[9+i] = v[7-i];
    return r;
  endfunction

  task automatic check(input string nm,
                       input logic [NR*8-1:0] act,
                       input logic [NR*8-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input bit wr,
                      input logic [6:0] a, input logic [7:0] d,
                      input int nedges, input logic [7:0] rd);
    exp_t e;
    int   ai;
    ai     = int'(a);
    e.name = nm;
    e.pb   = '0;
    e.sb   = '0;
    if (wr && nedges >= 17) begin
      e.sb[17] = 1'b1;
      if (ai < NR)
        mdl[ai*8 +: 8] = d;
    end
    if (!wr && nedges >= 16)
      e.pb = pmask(rdexp(rd));
    e.regs = mdl;
    q.push_back(e);
  endtask

  task automatic txn(input string nm, input bit wr,
                     input logic [6:0] a, input logic [7:0] d,
                     input int nedges, input logic [7:0] rd,
                     input bit scramble);
    push(nm, wr, a, d, nedges, rd);
    @(negedge spi_clk);
    cs       = 1'b0;
    is_write = wr;
    addr     = a;
    wdata    = d;
    for (int i = 1; i <= nedges; i++) begin
      @(posedge spi_clk);
      if (scramble && i == 9) begin
        #1;
        is_write = ~wr;
        addr     = ~a;
      end
    end
    if (nedges > 0)
      @(negedge spi_clk);
    #2 cs = 1'b1;
    repeat (2) @(negedge spi_clk);
  endtask

  // monitor: collect poci/strobe per edge, compare at cs rise
  initial begin
    logic [31:0] pb;
    logic [31:0] sb;
    int          e;
    exp_t        x;
    forever begin
      @(negedge cs);
      e  = 0;
      pb = '0;
      sb = '0;
      while (cs == 1'b0) begin
        @(posedge spi_clk or posedge cs);
        if (cs) break;
        e++;
        @(negedge spi_clk or posedge cs);
        if (cs) break;
        if (e < 32) begin
          pb[e] = poci;
          sb[e] = write_strobe;
        end
      end
      #1;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_txn: got 1 expected 0");
      end else begin
        x = q.pop_front();
        check({x.name, ".cs_hi"},
              {{(NR*8-2){1'b0}}, poci, write_strobe}, '0);
        check({x.name, ".poci"}, {{(NR*8-32){1'b0}}, pb},
              {{(NR*8-32){1'b0}}, x.pb});
        check({x.name, ".strobe"}, {{(NR*8-32){1'b0}}, sb},
              {{(NR*8-32){1'b0}}, x.sb});
        check({x.name, ".regs"}, regs_out, x.regs);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge spi_clk);
    rstn = 1'b1;
    repeat (2) @(negedge spi_clk);

    txn("rst_idle",   1'b0, 7'd0,  8'h00, 0,  8'h00, 1'b0);
    txn("rd3_reset",  1'b0, 7'd3,  8'h00, 17, 8'h00, 1'b0);
    txn("wr2_a5",     1'b1, 7'd2,  8'hA5, 17, 8'h00, 1'b1);
    txn("rd2_a5",     1'b0, 7'd2,  8'h00, 17, 8'hA5, 1'b0);
    txn("wr5_abort",  1'b1, 7'd5,  8'hFF, 12, 8'h00, 1'b0);
    txn("rd5_zero",   1'b0, 7'd5,  8'h00, 17, 8'h00, 1'b0);
    txn("rd_id",      1'b0, 7'h7F, 8'h00, 17, 8'h6C, 1'b0);
    txn("wr_id",      1'b1, 7'h7F, 8'h11, 17, 8'h00, 1'b0);
    txn("wr20",       1'b1, 7'd20, 8'h11, 17, 8'h00, 1'b0);
    txn("wr0_25edge", 1'b1, 7'd0,  8'h3C, 25, 8'h00, 1'b0);
    txn("wr1_96",     1'b1, 7'd1,  8'h96, 17, 8'h00, 1'b0);
    txn("rd1_96",     1'b0, 7'd1,  8'h00, 17, 8'h96, 1'b0);
    txn("rd20_zero",  1'b0, 7'd20, 8'h00, 17, 8'h00, 1'b0);
    txn("wr15_c3",    1'b1, 7'd15, 8'hC3, 17, 8'h00, 1'b0);
    txn("rd15_c3",    1'b0, 7'd15, 8'h00, 17, 8'hC3, 1'b0);
    txn("rd0_3c",     1'b0, 7'd0,  8'h00, 17, 8'h3C, 1'b0);

    // reset in the middle of a write, cs held low afterwards
    mdl = '0;
    push("rst_mid", 1'b0, 7'd0, 8'h00, 0, 8'h00);
    @(negedge spi_clk);
    cs       = 1'b0;
    is_write = 1'b1;
    addr     = 7'd1;
    wdata    = 8'hEE;
    repeat (5) @(posedge spi_clk);
    #2 rstn = 1'b0;
    #4 rstn = 1'b1;
    repeat (20) @(posedge spi_clk);
    @(negedge spi_clk);
    #2 cs = 1'b1;
    repeat (2) @(negedge spi_clk);

    txn("wr1_resume", 1'b1, 7'd1,  8'h5A, 17, 8'h00, 1'b0);

    for (int i = 0; i < 100 && q.size() > 0; i++)
      @(negedge spi_clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
